bp_cfg_loader: RTL and testbench

- Boot-time configuration sequencer that sits directly downstream of the processor parameter set.
- Given the core count and CCE microcode depth of the selected configuration, it issues the full config-register write stream that brings every core out of freeze.
- It drives a valid/ready config-write channel toward the per-core config links and tracks write acks with a credit counter.
- It asserts done_o once all cores are configured and released.

---
 rtl/bp_cfg_loader_pkg.sv | 34 +++
 rtl/bp_cfg_credit_counter.sv | 45 ++++
 rtl/bp_cfg_loader.sv | 142 ++++++++++++++
 tb/tb_bp_cfg_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_cfg_loader_pkg.sv
// Shared constants and types for the boot-time config loader.
// Config register map, loader FSM states and CCE mode encoding.
package bp_cfg_loader_pkg;

  localparam logic [15:0] ADDR_FREEZE     = 16'h0000;
  localparam logic [15:0] ADDR_CORE_ID    = 16'h0004;
  localparam logic [15:0] ADDR_CCE_MODE   = 16'h0008;
  localparam logic [15:0] ADDR_UCODE_BASE = 16'h8000;

  typedef enum logic [1:0] {
    e_cce_mode_uncached = 2'd0,
    e_cce_mode_normal   = 2'd1
  } bp_cce_mode_e;

  typedef enum logic [3:0] {
    e_reset,
    e_freeze,
    e_core_id,
    e_ucode_rd,
    e_ucode_wait,
    e_ucode_wr,
    e_cce_mode,
    e_drain_pre,
    e_unfreeze,
    e_drain,
    e_done
  } bp_cfg_loader_state_e;

  function automatic logic is_wr_state(bp_cfg_loader_state_e s);
    return (s == e_freeze) || (s == e_core_id) || (s == e_ucode_wr)
        || (s == e_cce_mode) || (s == e_unfreeze);
  endfunction

endpackage

// File: rtl/bp_cfg_credit_counter.sv
// Outstanding-write credit tracker for the config channel.
// Saturating up/down count, issue gate and sticky spurious-ack flag.
module bp_cfg_credit_counter #(
  parameter int max_p = 4,
  localparam int cw_lp = $clog2(max_p + 1)
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             v_i,
  input  logic             ack_i,
  output logic [cw_lp-1:0] credits_o,
  output logic             can_issue_o,
  output logic             error_o
);

  logic [cw_lp-1:0] cnt_q, cnt_n;
  logic             err_q;
  logic             at_max, empty, dec;

  assign at_max      = (cnt_q == cw_lp'(max_p));
  assign empty       = (cnt_q == '0);
  assign dec         = ack_i && !empty;
  assign can_issue_o = !at_max || ack_i;
  assign credits_o   = cnt_q;
  assign error_o     = err_q;

  always_comb begin
    cnt_n = cnt_q;
    if (v_i && !dec && !at_max)
      cnt_n = cnt_q + 1'b1;
    else if (!v_i && dec)
      cnt_n = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_n;
      err_q <= err_q || (ack_i && empty);
    end
  end

endmodule

// File: rtl/bp_cfg_loader.sv
// Boot config sequencer: freezes, identifies, loads CCE ucode and
// releases every core through a credited valid/ready write channel.
module bp_cfg_loader
  import bp_cfg_loader_pkg::*;
#(
  parameter int num_core_p        = 1,
  parameter int cce_pc_width_p    = 8,
  parameter int cfg_addr_width_p  = 16,
  parameter int cfg_data_width_p  = 64,
  parameter int max_outstanding_p = 4,
  localparam int core_w_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [core_w_lp-1:0]        cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  input  logic                        cfg_ack_v_i,
  output logic                        ucode_r_v_o,
  output logic [cce_pc_width_p-1:0]   ucode_addr_o,
  input  logic [cfg_data_width_p-1:0] ucode_data_i,
  output logic                        done_o,
  output logic                        error_o
);

  localparam int aw_lp = cfg_addr_width_p;
  localparam int dw_lp = cfg_data_width_p;
  localparam int crw_lp = $clog2(max_outstanding_p + 1);
  localparam logic [core_w_lp-1:0] last_core_lp = core_w_lp'(num_core_p - 1);

  bp_cfg_loader_state_e state_q, state_n;
  logic [core_w_lp-1:0]      core_q, core_n;
  logic [cce_pc_width_p-1:0] idx_q, idx_n;
  logic [dw_lp-1:0]          hold_q, hold_n;
  logic [crw_lp-1:0]         credits;
  logic can_issue, xfer, last_core;

  bp_cfg_credit_counter #(.max_p(max_outstanding_p)) credit (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .v_i         (xfer),
    .ack_i       (cfg_ack_v_i),
    .credits_o   (credits),
    .can_issue_o (can_issue),
    .error_o     (error_o)
  );

  assign cfg_v_o      = is_wr_state(state_q) && can_issue;
  assign xfer         = cfg_v_o && cfg_ready_i;
  assign last_core    = (core_q == last_core_lp);
  assign cfg_core_o   = core_q;
  assign ucode_addr_o = idx_q;
  assign done_o       = (state_q == e_done);

  always_comb begin
    cfg_addr_o = '0;
    cfg_data_o = '0;
    unique case (state_q)
      e_freeze: begin
        cfg_addr_o = aw_lp'(ADDR_FREEZE);
        cfg_data_o = dw_lp'(1'b1);
      end
      e_core_id: begin
        cfg_addr_o = aw_lp'(ADDR_CORE_ID);
        cfg_data_o = dw_lp'(core_q);
      end
      e_ucode_wr: begin
        cfg_addr_o = aw_lp'(ADDR_UCODE_BASE) + aw_lp'(idx_q);
        cfg_data_o = hold_q;
      end
      e_cce_mode: begin
        cfg_addr_o = aw_lp'(ADDR_CCE_MODE);
        cfg_data_o = dw_lp'(e_cce_mode_normal);
      end
      e_unfreeze: cfg_addr_o = aw_lp'(ADDR_FREEZE);
      default: ;
    endcase
  end

  always_comb begin
    state_n     = state_q;
    core_n      = core_q;
    idx_n       = idx_q;
    hold_n      = hold_q;
    ucode_r_v_o = 1'b0;
    unique case (state_q)
      e_reset: begin
        state_n = e_freeze;
        core_n  = '0;
        idx_n   = '0;
      end
      e_freeze, e_core_id, e_cce_mode, e_unfreeze: if (xfer) begin
        core_n = last_core ? '0 : core_q + 1'b1;
        if (last_core) begin
          unique case (state_q)
            e_freeze:   state_n = e_core_id;
            e_core_id:  state_n = e_ucode_rd;
            e_cce_mode: state_n = e_drain_pre;
            default:    state_n = e_drain;
          endcase
          idx_n = '0;
        end
      end
      e_ucode_rd: begin
        ucode_r_v_o = 1'b1;
        state_n     = e_ucode_wait;
      end
      e_ucode_wait: begin
        hold_n  = ucode_data_i;
        state_n = e_ucode_wr;
      end
      e_ucode_wr: if (xfer) begin
        state_n = e_ucode_rd;
        idx_n   = idx_q + 1'b1;
        if (idx_q == '1) begin
          core_n = last_core ? '0 : core_q + 1'b1;
          if (last_core) state_n = e_cce_mode;
        end
      end
      e_drain_pre: if (credits == '0) state_n = e_unfreeze;
      e_drain:     if (credits == '0) state_n = e_done;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_reset;
      core_q  <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_n;
      core_q  <= core_n;
      idx_q   <= idx_n;
      hold_q  <= hold_n;
    end
  end

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Scoreboard bench for bp_cfg_loader (2 cores, 4-entry ucode, 4 credits).
// Expected write stream is table-built; monitor pops and compares.
module tb_bp_cfg_loader;

  typedef struct {
    logic [0:0]  core;
    logic [15:0] addr;
    logic [63:0] data;
  } vec_t;

  vec_t tbl[16];
  vec_t exp_q[$];
  vec_t e;
  int   ack_q[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_ready = 1'b1;
  logic        ack = 1'b0;
  logic [63:0] ucode_data = '0;
  logic        cfg_v, ucode_r_v, done, error;
  logic [0:0]  cfg_core;
  logic [15:0] cfg_addr;
  logic [63:0] cfg_data;
  logic [1:0]  ucode_addr;

  int tests = 0, fails = 0, cyc = 0, acks = 0, xfers = 0, ack_dly = 2;
  bit ack_en = 1'b1, man_ack = 1'b0, rnd_ready = 1'b0;
  bit done_seen = 1'b0, prev_hold = 1'b0, rom_ld = 1'b0;
  logic [0:0]  p_core;
  logic [15:0] p_addr;
  logic [63:0] p_data, rom_next;

  bp_cfg_loader #(
    .num_core_p(2), .cce_pc_width_p(2), .cfg_addr_width_p(16),
    .cfg_data_width_p(64), .max_outstanding_p(4)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .cfg_v_o(cfg_v), .cfg_ready_i(cfg_ready),
    .cfg_core_o(cfg_core), .cfg_addr_o(cfg_addr), .cfg_data_o(cfg_data),
    .cfg_ack_v_i(ack),
    .ucode_r_v_o(ucode_r_v), .ucode_addr_o(ucode_addr),
    .ucode_data_i(ucode_data),
    .done_o(done), .error_o(error)
  );

  always #5 clk = ~clk;

  // input driver: ROM data, ready, acks (all 1 time unit after posedge)
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rom_ld) begin
      ucode_data = rom_next;
      rom_ld = 1'b0;
    end else ucode_data = 64'hDEAD_BEEF_0BAD_F00D;
    cfg_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    ack = 1'b0;
    if (rst_n && man_ack) ack = 1'b1;
    else if (rst_n && ack_en && ack_q.size() > 0 && ack_q[0] <= cyc) begin
      ack = 1'b1;
      void'(ack_q.pop_front());
      acks++;
    end
  end

  // monitor on the falling edge
  always @(negedge clk) begin
    if (!rst_n) prev_hold = 1'b0;
    else begin
      if (prev_hold) begin
        tests++;
        if (!cfg_v || cfg_core != p_core || cfg_addr != p_addr || cfg_data != p_data) begin
          fails++;
          $display("FAIL hold: v=%b core=%0d addr=%h data=%h, required v=1 core=%0d addr=%h data=%h",
                   cfg_v, cfg_core, cfg_addr, cfg_data, p_core, p_addr, p_data);
        end
      end
      if (ucode_r_v) begin
        rom_next = 64'hA0 + 64'(ucode_addr);
        rom_ld = 1'b1;
      end
      if (cfg_v && cfg_ready) begin
        xfers++;
        ack_q.push_back(cyc + ack_dly);
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL extra_xfer: core=%0d addr=%h data=%h, required no transfer",
                   cfg_core, cfg_addr, cfg_data);
        end else begin
          e = exp_q.pop_front();
          if (cfg_core != e.core || cfg_addr != e.addr || cfg_data != e.data) begin
            fails++;
            $display("FAIL xfer%0d: core=%0d addr=%h data=%h, required core=%0d addr=%h data=%h",
                     xfers, cfg_core, cfg_addr, cfg_data, e.core, e.addr, e.data);
          end
        end
        if (cfg_addr == 16'h0000 && cfg_data == 64'd0) begin
          tests++;
          if (acks < 14) begin
            fails++;
            $display("FAIL unfreeze_early: acks=%0d, required >=14", acks);
          end
        end
      end
      if (done && !done_seen) begin
        done_seen = 1'b1;
        tests++;
        if (acks != 16) begin
          fails++;
          $display("FAIL done_early: acks=%0d at done, required 16", acks);
        end
      end
      prev_hold = cfg_v && !cfg_ready;
      p_core = cfg_core;
      p_addr = cfg_addr;
      p_data = cfg_data;
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    ack_q.delete();
    foreach (tbl[i]) exp_q.push_back(tbl[i]);
    acks = 0;
    xfers = 0;
    done_seen = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_sb();
    @(posedge clk);
    #1;
    chk("rst_ctl", 64'({cfg_v, ucode_r_v, done, error, cfg_core, ucode_addr}), 64'd0);
    chk("rst_addr", 64'(cfg_addr), 64'd0);
    chk("rst_data", cfg_data, 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_done(string name, int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk({name, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic end_checks(string name, logic exp_err);
    chk({name, "_xfers"}, 64'(xfers), 64'd16);
    chk({name, "_left"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_err"}, 64'(error), 64'(exp_err));
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
  endtask

  int k;

  task automatic add(int c, logic [15:0] a, logic [63:0] d);
    tbl[k].core = 1'(c);
    tbl[k].addr = a;
    tbl[k].data = d;
    k = k + 1;
  endtask

  initial begin
    k = 0;
    for (int c = 0; c < 2; c++) add(c, 16'h0000, 64'd1);
    for (int c = 0; c < 2; c++) add(c, 16'h0004, 64'(c));
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 4; i++) add(c, 16'h8000 + 16'(i), 64'hA0 + 64'(i));
    for (int c = 0; c < 2; c++) add(c, 16'h0008, 64'd1);
    for (int c = 0; c < 2; c++) add(c, 16'h0000, 64'd0);

    // normal run
    do_reset();
    wait_done("normal", 2000);
    end_checks("normal", 1'b0);

    // acks withheld: credit limit then one-for-one release
    ack_en = 1'b0;
    do_reset();
    repeat (60) @(negedge clk);
    chk("withheld_xfers", 64'(xfers), 64'd4);
    chk("withheld_v", 64'(cfg_v), 64'd0);
    pulse_ack();
    repeat (20) @(negedge clk);
    chk("release_xfers", 64'(xfers), 64'd5);
    chk("release_v", 64'(cfg_v), 64'd0);
    ack_en = 1'b1;

    // random ready stalls
    rnd_ready = 1'b1;
    do_reset();
    wait_done("rnd", 3000);
    end_checks("rnd", 1'b0);
    rnd_ready = 1'b0;

    // long ack latency
    ack_dly = 20;
    do_reset();
    wait_done("slow", 3000);
    end_checks("slow", 1'b0);
    ack_dly = 2;

    // spurious ack right after reset
    do_reset();
    pulse_ack();
    @(negedge clk);
    chk("spur_err", 64'(error), 64'd1);
    wait_done("spur", 2000);
    end_checks("spur", 1'b1);

    // async reset in the middle of the ucode phase
    do_reset();
    for (int i = 0; i < 500 && xfers < 7; i++) @(negedge clk);
    chk("mid_reached", 64'(xfers >= 7), 64'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_ctl", 64'({cfg_v, ucode_r_v, done, error, cfg_core, ucode_addr}), 64'd0);
    chk("mid_addr", 64'(cfg_addr), 64'd0);
    chk("mid_data", cfg_data, 64'd0);
    clear_sb();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    wait_done("restart", 2000);
    end_checks("restart", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
